rat_io_responder: RTL and testbench
===================================

Name: rat_io_responder

Overview:
- Peripheral-side responder for the RAT MCU port bus.
- Decodes PORT_ID/IO_STRB writes from the MCU's OUT_PORT into peripheral registers (LEDs, 7-seg value, timer, IRQ mask/ack).
- Drives the MCU's IN_PORT combinationally for IN instructions.
- Raises INTR from a prescaled 16-bit timer and from debounced-free button rising edges.

Parameters:
- PRESCALE, 100, clocks per timer tick (≥2).
- SYNC_STAGES, 2, flip-flop depth of the button synchronizer (≥2).

Ports:
- CLK  in  1  system clock, rising-edge.
- RESET  in  1  asynchronous, active-high reset.
- PORT_ID  in  8  port address from MCU.
- OUT_PORT  in  8  write data from MCU (DX_OUT).
- IO_STRB  in  1  write strobe, one cycle per OUT instruction.
- IN_PORT  out  8  read data to MCU, combinational on PORT_ID.
- INTR  out  1  interrupt request to MCU, level.
- SWITCHES  in  8  board switches, static, unsynchronized.
- BUTTONS  in  4  board buttons, asynchronous.
- LEDS  out  8  LED register.
- SSEG_VAL  out  8  value for the 7-seg driver.

Behaviour:
- Port map:
  - 0x20 R SWITCHES.
  - 0x24 R {4'b0, synced BUTTONS}.
  - 0x30 R IRQ_PEND {6'b0, btn, tmr}.
  - 0x40 R/W LEDS.
  - 0x81 W SSEG_VAL.
  - 0xB0 W TIMER_LOAD[7:0].
  - 0xB1 W TIMER_LOAD[15:8].
  - 0xB2 R/W TIMER_CTRL {6'b0, autoreload, enable}.
  - 0xF0 W IRQ_ACK (write-1-to-clear IRQ_PEND bits).
  - 0xF1 R/W IRQ_MASK[1:0].
- Unmapped reads return 0x00. Unmapped writes are ignored.
- Writes: registered on the CLK edge where IO_STRB=1. The new value is visible on outputs and IN_PORT the next cycle.
- IN_PORT: purely combinational from PORT_ID. It is independent of IO_STRB.
- Reset (async): LEDS=0, SSEG_VAL=0, TIMER_LOAD=0, TIMER_CTRL=0, counter=0, prescaler=0, IRQ_PEND=0, IRQ_MASK=0, synchronizer flops=0, INTR=0.
- Prescaler:
  - Free-running 0..PRESCALE-1 while TIMER_CTRL.enable=1.
  - Tick asserts on the cycle it wraps to 0.
  - Held at 0 while disabled.
- Timer states:
  - IDLE (enable=0) → on write of enable=1: load counter from TIMER_LOAD, prescaler=0 → RUN.
  - RUN: on each tick, counter decrements.
  - Tick with counter==1, or counter==0 at entry: set IRQ_PEND.tmr, then:
    - autoreload=1: reload TIMER_LOAD and stay in RUN;
    - otherwise: clear enable → IDLE.
  - TIMER_LOAD=0: expiry occurs on the first tick.
  - Write of enable=0 in RUN → IDLE immediately. Pending bits are unaffected.
  - Write to TIMER_LOAD while in RUN takes effect only at the next reload.
- Buttons:
  - SYNC_STAGES-deep synchronizer, then a previous-value flop.
  - Any 0→1 transition on any bit sets IRQ_PEND.btn.
- INTR = |(IRQ_PEND & IRQ_MASK), registered (one cycle after the pending/mask change).
- Simultaneous ack and event on the same bit in one cycle: event wins, bit stays 1.
- Masked events still set IRQ_PEND. Unmasking later asserts INTR.
- Reset mid-count: all state returns to reset values immediately, asynchronously.

Optional Feature:
- Macro: RAT_IO_TIMER_EN.
- Defined: timer, prescaler, and ports 0xB0–0xB2 are present as described.
- Undefined:
  - No timer or prescaler logic.
  - Writes to 0xB0–0xB2 are ignored, and reads of 0xB2 return 0x00.
  - IRQ_PEND.tmr is tied to 0.
  - The button path is unchanged.

Test Plan:
- Reset then read: RESET pulse mid-sim → LEDS=0x00, SSEG_VAL=0x00, INTR=0. PORT_ID=0x30 → IN_PORT=0x00.
- LED write/readback: IO_STRB with PORT_ID=0x40, OUT_PORT=0xA5 → LEDS=0xA5 next cycle. PORT_ID=0x40 → IN_PORT=0xA5. PORT_ID=0x55 → IN_PORT=0x00.
- One-shot timer: PRESCALE=4, LOAD=0x0003, MASK=0x01, CTRL=0x01 → INTR rises 13 cycles after the CTRL write edge (12 clocks plus the register stage). Then CTRL reads 0x00 and IRQ_PEND=0x01.
- Autoreload and ack:
  - Same setup with CTRL=0x03 → IRQ_PEND.tmr sets every 12 cycles.
  - Write 0xF0←0x01 → INTR falls next cycle.
  - An ack coincident with expiry leaves the bit set.
- Buttons:
  - BUTTONS[2] 0→1 with MASK=0x02 → INTR=1 within SYNC_STAGES+2 cycles, IRQ_PEND=0x02.
  - Holding high causes no re-trigger after ack.
  - With MASK=0 → IRQ_PEND=0x02 and INTR=0.
- RAT_IO_TIMER_EN undefined: CTRL=0x01 with LOAD=0 → IRQ_PEND.tmr stays 0 for 1000 cycles, and PORT_ID=0xB2 → IN_PORT=0x00.

Source files
------------

// File: rtl/rat_io_responder.sv
// RAT MCU port-bus responder: LED/7-seg registers, IRQ pending/mask/ack, button edge IRQ.
// Define RAT_IO_TIMER_EN to build the prescaled 16-bit timer and its ports 0xB0-0xB2.
`timescale 1ns/1ps
module rat_io_responder #(
  parameter int PRESCALE    = 100,
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] PORT_ID,
  input  logic [7:0] OUT_PORT,
  input  logic       IO_STRB,
  output logic [7:0] IN_PORT,
  output logic       INTR,
  input  logic [7:0] SWITCHES,
  input  logic [3:0] BUTTONS,
  output logic [7:0] LEDS,
  output logic [7:0] SSEG_VAL
);

  if (PRESCALE < 2 || SYNC_STAGES < 2) begin : gParamCheck
    $error("rat_io_responder: PRESCALE and SYNC_STAGES must both be at least 2");
  end

  logic [7:0] leds_q, sseg_q;
  logic [1:0] mask_q, pend_q, pend_d;
  logic       intr_q;
  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic [3:0] btnSynced, btnPrev_q;
  logic       btnEvent, tmrEvent;
  logic [7:0] tmrCtrlRd;
  logic       ledWr, ssegWr, ackWr, maskWr;
  logic [1:0] ackBits;

  assign ledWr  = IO_STRB && (PORT_ID == 8'h40);
  assign ssegWr = IO_STRB && (PORT_ID == 8'h81);
  assign ackWr  = IO_STRB && (PORT_ID == 8'hF0);
  assign maskWr = IO_STRB && (PORT_ID == 8'hF1);

  assign btnSynced = sync_q[SYNC_STAGES-1];
  assign btnEvent  = |(btnSynced & ~btnPrev_q);

`ifdef RAT_IO_TIMER_EN
  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  typedef enum logic {TMR_IDLE, TMR_RUN} tmrState_e;

  tmrState_e   tmrState_q;
  logic [15:0] tmrLoad_q, tmrCount_q;
  logic [PW-1:0] presc_q;
  logic        autoReload_q;
  logic        loadLoWr, loadHiWr, ctrlWr, stopWr, tick;

  assign loadLoWr = IO_STRB && (PORT_ID == 8'hB0);
  assign loadHiWr = IO_STRB && (PORT_ID == 8'hB1);
  assign ctrlWr   = IO_STRB && (PORT_ID == 8'hB2);
  assign stopWr   = ctrlWr && !OUT_PORT[0];
  assign tick     = (tmrState_q == TMR_RUN) && (presc_q == PRESC_MAX);
  // A counter of 0 (LOAD=0) expires on the first tick just like a counter of 1.
  assign tmrEvent = tick && (tmrCount_q <= 16'd1) && !stopWr;
  assign tmrCtrlRd = {6'b0, autoReload_q, tmrState_q == TMR_RUN};

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      tmrState_q   <= TMR_IDLE;
      tmrLoad_q    <= '0;
      tmrCount_q   <= '0;
      presc_q      <= '0;
      autoReload_q <= 1'b0;
    end else begin
      if (loadLoWr) tmrLoad_q[7:0]  <= OUT_PORT;
      if (loadHiWr) tmrLoad_q[15:8] <= OUT_PORT;
      if (ctrlWr)   autoReload_q    <= OUT_PORT[1];
      if (stopWr) begin
        tmrState_q <= TMR_IDLE;
        presc_q    <= '0;
      end else if (ctrlWr && tmrState_q == TMR_IDLE) begin
        tmrState_q <= TMR_RUN;
        tmrCount_q <= tmrLoad_q;
        presc_q    <= '0;
      end else if (tmrState_q == TMR_RUN) begin
        presc_q <= tick ? '0 : presc_q + 1'b1;
        if (tick) begin
          if (tmrCount_q <= 16'd1) begin
            if (autoReload_q) tmrCount_q <= tmrLoad_q;
            else              tmrState_q <= TMR_IDLE;
          end else begin
            tmrCount_q <= tmrCount_q - 16'd1;
          end
        end
      end
    end
  end
`else
  assign tmrEvent  = 1'b0;
  assign tmrCtrlRd = 8'h00;
`endif

  // A new event beats an ack of the same bit in the same cycle.
  always_comb begin
    ackBits = ackWr ? OUT_PORT[1:0] : 2'b00;
    pend_d  = (pend_q & ~ackBits) | {btnEvent, tmrEvent};
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      leds_q    <= '0;
      sseg_q    <= '0;
      mask_q    <= '0;
      pend_q    <= '0;
      intr_q    <= 1'b0;
      sync_q    <= '0;
      btnPrev_q <= '0;
    end else begin
      if (ledWr)  leds_q <= OUT_PORT;
      if (ssegWr) sseg_q <= OUT_PORT;
      if (maskWr) mask_q <= OUT_PORT[1:0];
      pend_q    <= pend_d;
      intr_q    <= |(pend_q & mask_q);
      sync_q    <= {sync_q[SYNC_STAGES-2:0], BUTTONS};
      btnPrev_q <= btnSynced;
    end
  end

  always_comb begin
    IN_PORT = 8'h00;
    case (PORT_ID)
      8'h20:   IN_PORT = SWITCHES;
      8'h24:   IN_PORT = {4'b0, btnSynced};
      8'h30:   IN_PORT = {6'b0, pend_q};
      8'h40:   IN_PORT = leds_q;
      8'hB2:   IN_PORT = tmrCtrlRd;
      8'hF1:   IN_PORT = {6'b0, mask_q};
      default: IN_PORT = 8'h00;
    endcase
  end

  assign INTR     = intr_q;
  assign LEDS     = leds_q;
  assign SSEG_VAL = sseg_q;

endmodule

// File: tb/tb_rat_io_responder.sv
// Self-checking bench for rat_io_responder: behavioural model plus directed and random stimulus.
// Timer scenarios are included only when RAT_IO_TIMER_EN is defined.
`timescale 1ns/1ps
module tb_rat_io_responder;

  localparam int PRESCALE = 4;
  localparam int SYNC     = 2;

  logic       CLK, RESET, IO_STRB, INTR;
  logic [7:0] PORT_ID, OUT_PORT, IN_PORT, SWITCHES, LEDS, SSEG_VAL;
  logic [3:0] BUTTONS;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  rat_io_responder #(.PRESCALE(PRESCALE), .SYNC_STAGES(SYNC)) dut (
    .CLK(CLK), .RESET(RESET), .PORT_ID(PORT_ID), .OUT_PORT(OUT_PORT),
    .IO_STRB(IO_STRB), .IN_PORT(IN_PORT), .INTR(INTR), .SWITCHES(SWITCHES),
    .BUTTONS(BUTTONS), .LEDS(LEDS), .SSEG_VAL(SSEG_VAL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Behavioural model: timer tracked as "cycles to next tick" and "ticks to expiry".
  logic [7:0] mLeds, mSseg;
  logic [1:0] mMask, mPend;
  logic       mIntr;
  logic [3:0] bHist [0:SYNC];
`ifdef RAT_IO_TIMER_EN
  bit mRun, mAuto;
  int mLoad, mTicksLeft, mCyclesToTick;
`endif

  function automatic bit modelRun();
`ifdef RAT_IO_TIMER_EN
    return mRun;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [7:0] expRead(input logic [7:0] id);
    case (id)
      8'h20:   return SWITCHES;
      8'h24:   return {4'b0, bHist[SYNC-1]};
      8'h30:   return {6'b0, mPend};
      8'h40:   return mLeds;
`ifdef RAT_IO_TIMER_EN
      8'hB2:   return {6'b0, mAuto, mRun};
`endif
      8'hF1:   return {6'b0, mMask};
      default: return 8'h00;
    endcase
  endfunction

  task automatic modelReset();
    mLeds = 8'h00; mSseg = 8'h00; mMask = 2'b00; mPend = 2'b00; mIntr = 1'b0;
    for (int i = 0; i <= SYNC; i++) bHist[i] = 4'h0;
`ifdef RAT_IO_TIMER_EN
    mRun = 0; mAuto = 0; mLoad = 0; mTicksLeft = 0; mCyclesToTick = 0;
`endif
  endtask

  task automatic modelStep();
    logic [1:0] ev;
    logic [1:0] ack;
`ifdef RAT_IO_TIMER_EN
    bit wasRun;
`endif
    ev  = 2'b00;
    ack = 2'b00;
    if (|(bHist[SYNC-1] & ~bHist[SYNC])) ev[1] = 1'b1;
    for (int i = SYNC; i > 0; i--) bHist[i] = bHist[i-1];
    bHist[0] = BUTTONS;
`ifdef RAT_IO_TIMER_EN
    wasRun = mRun;
    if (mRun && !(IO_STRB && PORT_ID == 8'hB2 && !OUT_PORT[0])) begin
      mCyclesToTick--;
      if (mCyclesToTick == 0) begin
        mCyclesToTick = PRESCALE;
        mTicksLeft--;
        if (mTicksLeft == 0) begin
          ev[0] = 1'b1;
          if (mAuto) mTicksLeft = (mLoad == 0) ? 1 : mLoad;
          else       mRun = 0;
        end
      end
    end
`endif
    mIntr = |(mPend & mMask);
    if (IO_STRB) begin
      case (PORT_ID)
        8'h40: mLeds = OUT_PORT;
        8'h81: mSseg = OUT_PORT;
        8'hF0: ack   = OUT_PORT[1:0];
        8'hF1: mMask = OUT_PORT[1:0];
`ifdef RAT_IO_TIMER_EN
        8'hB0: mLoad = (mLoad & 32'hFF00) | int'(OUT_PORT);
        8'hB1: mLoad = (mLoad & 32'h00FF) | (int'(OUT_PORT) << 8);
        8'hB2: begin
          mAuto = OUT_PORT[1];
          if (!OUT_PORT[0]) mRun = 0;
          else if (!wasRun) begin
            mRun          = 1;
            mTicksLeft    = (mLoad == 0) ? 1 : mLoad;
            mCyclesToTick = PRESCALE;
          end
        end
`endif
        default: ;
      endcase
    end
    mPend = (mPend & ~ack) | ev;
  endtask

  always @(posedge CLK or posedge RESET) begin
    if (RESET) modelReset();
    else       modelStep();
  end

  task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%02h want=%02h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  // Every cycle, after the edge settles, the DUT must agree with the model.
  always @(posedge CLK) begin
    #1;
    checkOutput("LEDS", LEDS, mLeds);
    checkOutput("SSEG_VAL", SSEG_VAL, mSseg);
    checkOutput("INTR", {7'b0, INTR}, {7'b0, mIntr});
    checkOutput("IN_PORT", IN_PORT, expRead(PORT_ID));
  end

  task automatic applyStimulus(input logic [7:0] id, input logic [7:0] data, input logic strb);
    @(negedge CLK);
    PORT_ID  = id;
    OUT_PORT = data;
    IO_STRB  = strb;
  endtask

  task automatic writePort(input logic [7:0] id, input logic [7:0] data);
    applyStimulus(id, data, 1'b1);
    applyStimulus(id, data, 1'b0);
  endtask

  task automatic readPort(input logic [7:0] id, input string name, input logic [7:0] exp);
    applyStimulus(id, 8'h00, 1'b0);
    #1;
    checkOutput(name, IN_PORT, exp);
  endtask

  task automatic waitIntr(input int limit, output int seen);
    seen = -1;
    for (int k = 1; k <= limit; k++) begin
      @(posedge CLK);
      #1;
      if (INTR) begin
        seen = cyc;
        break;
      end
    end
  endtask

  logic [7:0] ports [12] = '{8'h20, 8'h24, 8'h30, 8'h40, 8'h81, 8'hB0,
                             8'hB1, 8'hB2, 8'hF0, 8'hF1, 8'h55, 8'h00};

  initial begin
    int seen, t0, r1, r2;
    logic [7:0] id, data;
    RESET = 1'b0; IO_STRB = 1'b0; PORT_ID = 8'h00; OUT_PORT = 8'h00;
    SWITCHES = 8'h5A; BUTTONS = 4'h0;
    #2 RESET = 1'b1;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;

    checkOutput("rstLeds", LEDS, 8'h00);
    checkOutput("rstSseg", SSEG_VAL, 8'h00);
    checkOutput("rstIntr", {7'b0, INTR}, 8'h00);
    readPort(8'h30, "rstPend", 8'h00);
    readPort(8'h20, "switches", 8'h5A);

    writePort(8'h40, 8'hA5);
    #1 checkOutput("ledWrite", LEDS, 8'hA5);
    readPort(8'h40, "ledRead", 8'hA5);
    readPort(8'h55, "unmapped", 8'h00);
    writePort(8'h81, 8'h3C);
    #1 checkOutput("ssegWrite", SSEG_VAL, 8'h3C);
    writePort(8'h20, 8'hFF);
    readPort(8'h20, "roSwitches", 8'h5A);

    // Button edge with the button IRQ unmasked.
    writePort(8'hF1, 8'h02);
    applyStimulus(8'h30, 8'h00, 1'b0);
    BUTTONS = 4'b0100;
    waitIntr(SYNC + 2, seen);
    checkOutput("btnIntrInTime", {7'b0, seen >= 0}, 8'h01);
    readPort(8'h30, "btnPend", 8'h02);
    readPort(8'h24, "btnSynced", 8'h04);
    writePort(8'hF0, 8'h02);
    repeat (4) @(negedge CLK);
    checkOutput("btnNoRetrigIntr", {7'b0, INTR}, 8'h00);
    readPort(8'h30, "btnNoRetrigPend", 8'h00);
    writePort(8'hF1, 8'h00);
    BUTTONS = 4'b0000;
    repeat (5) @(negedge CLK);
    BUTTONS = 4'b0100;
    repeat (6) @(negedge CLK);
    readPort(8'h30, "btnMaskedPend", 8'h02);
    checkOutput("btnMaskedIntr", {7'b0, INTR}, 8'h00);
    writePort(8'hF0, 8'h02);
    BUTTONS = 4'b0000;

`ifdef RAT_IO_TIMER_EN
    // One-shot: LOAD=3 with PRESCALE=4 expires 12 clocks after the CTRL write.
    writePort(8'hB0, 8'h03);
    writePort(8'hB1, 8'h00);
    writePort(8'hF1, 8'h01);
    applyStimulus(8'hB2, 8'h01, 1'b1);
    @(posedge CLK);
    #1 t0 = cyc;
    applyStimulus(8'h30, 8'h00, 1'b0);
    waitIntr(60, seen);
    checkOutput("oneShotLatency", 8'(seen - t0), 8'd13);
    readPort(8'hB2, "oneShotCtrl", 8'h00);
    readPort(8'h30, "oneShotPend", 8'h01);
    writePort(8'hF0, 8'h01);
    repeat (2) @(negedge CLK);

    // Autoreload period, ack release, and ack coincident with expiry.
    writePort(8'hB2, 8'h03);
    waitIntr(60, r1);
    checkOutput("autoFirstSeen", {7'b0, r1 >= 0}, 8'h01);
    writePort(8'hF0, 8'h01);
    @(posedge CLK);
    #1 checkOutput("ackIntrFall", {7'b0, INTR}, 8'h00);
    waitIntr(60, r2);
    checkOutput("autoPeriod", 8'(r2 - r1), 8'd12);
    writePort(8'hF0, 8'h01);
    while (cyc < r2 + 10) begin
      @(posedge CLK);
      #1;
    end
    applyStimulus(8'hF0, 8'h01, 1'b1);
    readPort(8'h30, "ackVsExpiry", 8'h01);
    writePort(8'hB2, 8'h00);
    writePort(8'hF0, 8'h01);
    readPort(8'hB2, "stopCtrl", 8'h00);
`else
    // Without the timer, its ports are inert.
    writePort(8'hB0, 8'h00);
    writePort(8'hF1, 8'h01);
    writePort(8'hB2, 8'h01);
    repeat (1000) @(negedge CLK);
    readPort(8'h30, "noTimerPend", 8'h00);
    readPort(8'hB2, "noTimerCtrl", 8'h00);
    checkOutput("noTimerIntr", {7'b0, INTR}, 8'h00);
`endif

    // Random traffic; the model follows every cycle. One reset lands mid-run.
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) begin
        @(negedge CLK);
        IO_STRB = 1'b0;
        PORT_ID = 8'h30;
        RESET   = 1'b1;
        #1;
        checkOutput("midRstLeds", LEDS, 8'h00);
        checkOutput("midRstSseg", SSEG_VAL, 8'h00);
        checkOutput("midRstIntr", {7'b0, INTR}, 8'h00);
        checkOutput("midRstPend", IN_PORT, 8'h00);
        @(negedge CLK);
        RESET = 1'b0;
      end
      id   = ports[$urandom_range(0, 11)];
      data = 8'($urandom);
      if (id == 8'hB0) data = data & 8'h07;
      if (id == 8'hB1) data = 8'h00;
      if (id == 8'hB2 && modelRun()) data = data & 8'hFE;
      if ($urandom_range(0, 15) == 0) BUTTONS = 4'($urandom);
      if ($urandom_range(0, 31) == 0) SWITCHES = 8'($urandom);
      applyStimulus(id, data, $urandom_range(0, 3) == 0);
    end
    applyStimulus(8'h00, 8'h00, 1'b0);
    repeat (2) @(negedge CLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
